// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/ready port bundle.
// master = access unit, slave = data memory.
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access FSM (IDLE/BUSY/DONE).
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid_MEM,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata_in,
    output logic [31:0]       rdata_MEM,
    output logic              stall_mem,
    output logic              bus_err,
    output logic              misalign,
    mem_access_unit_if.master dmem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_lane;
    logic [2:0]  r_f3;
    logic [31:0] r_rdata;
    logic        r_bus_err;
    logic [31:0] r_cnt;

    logic        w_acc;
    logic        w_mis;
    logic        w_issue;
    logic        w_done_ok;
    logic        w_abort;
    logic        w_timeout;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_acc     = valid_MEM & (mem_rd | mem_wr);
    assign stall_mem = w_acc & (r_state != S_DONE);

`ifdef MISALIGN_TRAP_EN
    logic r_misalign;
    assign w_mis = ((funct3[1:0] == 2'b01) & addr[0])
                 | ((funct3 == 3'b010) & (addr[1:0] != 2'b00));
    assign misalign = r_misalign;
`else
    assign w_mis    = 1'b0;
    assign misalign = 1'b0;
`endif

    // Counter counts completed BUSY cycles; abort on the WAIT_LIMIT-th one
    assign w_timeout = (WAIT_LIMIT != 0)
                     && ((r_cnt + 32'd1) >= WAIT_LIMIT);

    assign w_issue   = (r_state == S_IDLE) & w_acc & ~w_mis;
    assign w_done_ok = (r_state == S_BUSY) & dmem.dmem_ready;
    assign w_abort   = (r_state == S_BUSY) & ~dmem.dmem_ready
                     & w_timeout;

    always_comb begin
        w_wdata = wdata_in;
        w_wstrb = 4'b1111;
        unique case (funct3[1:0])
            2'b00: begin
                w_wdata = {4{wdata_in[7:0]}};
                w_wstrb = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                w_wdata = {2{wdata_in[15:0]}};
                w_wstrb = 4'b0011 << {addr[1], 1'b0};
            end
            default: w_wstrb = 4'b1111;
        endcase
        if (!mem_wr) begin
            w_wstrb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = dmem.dmem_rdata[7:0];
        unique case (r_lane)
            2'd0: w_byte = dmem.dmem_rdata[7:0];
            2'd1: w_byte = dmem.dmem_rdata[15:8];
            2'd2: w_byte = dmem.dmem_rdata[23:16];
            2'd3: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? dmem.dmem_rdata[31:16]
                           : dmem.dmem_rdata[15:0];
        unique case (r_f3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'h0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_state_nxt = w_mis ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (dmem.dmem_ready || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_wstrb   <= 4'h0;
            r_lane    <= 2'h0;
            r_f3      <= 3'h0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b0;
            r_cnt     <= 32'h0;
        end else begin
            if (w_issue) begin
                r_req   <= 1'b1;
                r_we    <= mem_wr;
                r_addr  <= {addr[31:2], 2'b00};
                r_lane  <= addr[1:0];
                r_f3    <= funct3;
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
                r_cnt   <= 32'h0;
            end else if (r_state == S_BUSY) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_done_ok || w_abort) begin
                r_req <= 1'b0;
            end
            if (w_done_ok && !r_we) begin
                r_rdata <= w_load;
            end
            if (w_abort) begin
                r_rdata   <= 32'h0;
                r_bus_err <= 1'b1;
            end
            if (r_state == S_DONE) begin
                r_bus_err <= 1'b0;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_misalign <= 1'b0;
        end else if ((r_state == S_IDLE) && w_acc && w_mis) begin
            r_misalign <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_misalign <= 1'b0;
        end
    end
`endif

    // Trapped accesses force the load result to zero
`ifdef MISALIGN_TRAP_EN
    assign rdata_MEM = (r_misalign) ? 32'h0 : r_rdata;
`else
    assign rdata_MEM = r_rdata;
`endif

    assign bus_err         = r_bus_err;
    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_wstrb = r_wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
// Built with WAIT_LIMIT=4 so the watchdog path is exercised.
module tb_mem_access_unit;

    logic        clk;
    logic        rstn;
    logic        valid_MEM;
    logic        mem_rd;
    logic        mem_wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata_in;
    logic [31:0] rdata_MEM;
    logic        stall_mem;
    logic        bus_err;
    logic        misalign;

    int total = 0;
    int bad   = 0;
    int st;

    mem_access_unit_if dif ();

    mem_access_unit #(.WAIT_LIMIT(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_MEM (valid_MEM),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .funct3    (funct3),
        .addr      (addr),
        .wdata_in  (wdata_in),
        .rdata_MEM (rdata_MEM),
        .stall_mem (stall_mem),
        .bus_err   (bus_err),
        .misalign  (misalign),
        .dmem      (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        valid_MEM = v;
        mem_rd    = rd;
        mem_wr    = wr;
        funct3    = f3;
        addr      = a;
        wdata_in  = wd;
    endtask

    // Runs one access already presented in the current cycle; ready
    // arrives in BUSY cycle waits+1. Ends 1 time unit into DONE.
    task automatic access(input string tag, input int waits,
                          input logic [31:0] rd,
                          input logic [31:0] e_addr,
                          input logic [31:0] e_wdata,
                          input logic [3:0] e_wstrb,
                          input logic e_we, output int stalls);
        #1;
        stalls = 0;
        for (int c = 0; c < 20; c++) begin
            if (!stall_mem) break;
            stalls++;
            @(negedge clk);
            dif.dmem_ready = (c == waits);
            dif.dmem_rdata = (c == waits) ? rd : 32'h0;
            #1;
            if (stall_mem) begin
                chk({tag, ".req"},   {31'h0, dif.dmem_req}, 32'h1);
                chk({tag, ".addr"},  dif.dmem_addr, e_addr);
                chk({tag, ".wdata"}, dif.dmem_wdata, e_wdata);
                chk({tag, ".wstrb"}, {28'h0, dif.dmem_wstrb},
                    {28'h0, e_wstrb});
                chk({tag, ".we"},    {31'h0, dif.dmem_we},
                    {31'h0, e_we});
            end
        end
        dif.dmem_ready = 1'b0;
    endtask

    task automatic done_chk(input string tag, input int stalls,
                            input int e_st, input logic [31:0] e_rd,
                            input logic e_berr);
        chk({tag, ".stalls"},  stalls, e_st);
        chk({tag, ".rdata"},   rdata_MEM, e_rd);
        chk({tag, ".berr"},    {31'h0, bus_err}, {31'h0, e_berr});
        chk({tag, ".mis"},     {31'h0, misalign}, 32'h0);
        chk({tag, ".req_off"}, {31'h0, dif.dmem_req}, 32'h0);
    endtask

    initial begin
        rstn           = 1'b1;
        valid_MEM      = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        funct3         = 3'b000;
        addr           = 32'h0;
        wdata_in       = 32'h0;
        dif.dmem_ready = 1'b0;
        dif.dmem_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst.rdata", rdata_MEM, 32'h0);
        chk("rst.stall", {31'h0, stall_mem}, 32'h0);
        chk("rst.berr",  {31'h0, bus_err}, 32'h0);
        chk("rst.mis",   {31'h0, misalign}, 32'h0);
        chk("rst.req",   {31'h0, dif.dmem_req}, 32'h0);
        chk("rst.we",    {31'h0, dif.dmem_we}, 32'h0);
        chk("rst.addr",  dif.dmem_addr, 32'h0);
        chk("rst.wdata", dif.dmem_wdata, 32'h0);
        chk("rst.wstrb", {28'h0, dif.dmem_wstrb}, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("idle.req", {31'h0, dif.dmem_req}, 32'h0);

        drive(1, 1, 0, 3'b000, 32'h0000_1003, 32'h0);
        access("lb", 0, 32'h8011_2233, 32'h0000_1000, 32'h0, 4'h0, 0, st);
        done_chk("lb", st, 2, 32'hFFFF_FF80, 0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("lb.hold", rdata_MEM, 32'hFFFF_FF80);

        drive(1, 0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF);
        access("sh", 3, 32'h0, 32'h0000_2000, 32'hBEEF_BEEF, 4'b1100, 1,
               st);
        done_chk("sh", st, 5, 32'hFFFF_FF80, 0);

        drive(1, 1, 0, 3'b100, 32'h0000_1002, 32'h0);
        access("lbu", 1, 32'h11F2_3344, 32'h0000_1000, 32'h0, 4'h0, 0, st);
        done_chk("lbu", st, 3, 32'h0000_00F2, 0);

        drive(1, 1, 0, 3'b001, 32'h0000_1002, 32'h0);
        access("lh", 0, 32'h8001_7FFF, 32'h0000_1000, 32'h0, 4'h0, 0, st);
        done_chk("lh", st, 2, 32'hFFFF_8001, 0);

        drive(1, 1, 0, 3'b101, 32'h0000_1000, 32'h0);
        access("lhu", 0, 32'h1234_9ABC, 32'h0000_1000, 32'h0, 4'h0, 0,
               st);
        done_chk("lhu", st, 2, 32'h0000_9ABC, 0);

        drive(1, 0, 1, 3'b000, 32'h0000_4001, 32'h0000_00A5);
        access("sb", 0, 32'h0, 32'h0000_4000, 32'hA5A5_A5A5, 4'b0010, 1,
               st);
        done_chk("sb", st, 2, 32'h0000_9ABC, 0);

        drive(1, 0, 1, 3'b010, 32'h0000_5000, 32'h1234_5678);
        access("sw", 0, 32'h0, 32'h0000_5000, 32'h1234_5678, 4'b1111, 1,
               st);
        done_chk("sw", st, 2, 32'h0000_9ABC, 0);

        drive(1, 1, 0, 3'b010, 32'h0000_3000, 32'h0);
        access("lw", 2, 32'hCAFE_F00D, 32'h0000_3000, 32'h0, 4'h0, 0, st);
        done_chk("lw", st, 4, 32'hCAFE_F00D, 0);

        drive(1, 1, 0, 3'b010, 32'h0000_6000, 32'h0);
        access("wd", 100, 32'h0, 32'h0000_6000, 32'h0, 4'h0, 0, st);
        done_chk("wd", st, 5, 32'h0, 1);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("wd.berr_clr", {31'h0, bus_err}, 32'h0);

        drive(1, 1, 0, 3'b010, 32'h0000_3000, 32'h0);
        access("lw2", 0, 32'h0BAD_CAFE, 32'h0000_3000, 32'h0, 4'h0, 0,
               st);
        done_chk("lw2", st, 2, 32'h0BAD_CAFE, 0);

        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        dif.dmem_ready = 1'b1;
        dif.dmem_rdata = 32'hFFFF_FFFF;
        #1;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        dif.dmem_ready = 1'b0;
        #1;
        chk("idle_rdy.rdata", rdata_MEM, 32'h0BAD_CAFE);
        chk("idle_rdy.req",   {31'h0, dif.dmem_req}, 32'h0);

        drive(1, 1, 0, 3'b010, 32'h0000_7000, 32'h0);
        drive(1, 1, 0, 3'b010, 32'h0000_7000, 32'h0);
        #1;
        chk("rmb.busy_req", {31'h0, dif.dmem_req}, 32'h1);
        drive(1, 1, 0, 3'b010, 32'h0000_7000, 32'h0);
        rstn = 1'b1;
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        rstn           = 1'b0;
        dif.dmem_ready = 1'b1;
        dif.dmem_rdata = 32'h5555_AAAA;
        #1;
        chk("rmb.req",   {31'h0, dif.dmem_req}, 32'h0);
        chk("rmb.stall", {31'h0, stall_mem}, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        dif.dmem_ready = 1'b0;
        #1;
        chk("rmb.rdata", rdata_MEM, 32'h0);
        chk("rmb.req2",  {31'h0, dif.dmem_req}, 32'h0);
        chk("rmb.addr",  dif.dmem_addr, 32'h0);

`ifdef MISALIGN_TRAP_EN
        drive(1, 1, 0, 3'b010, 32'h0000_3001, 32'h0);
        #1;
        chk("mis.stall0", {31'h0, stall_mem}, 32'h1);
        @(negedge clk);
        #1;
        chk("mis.stall1", {31'h0, stall_mem}, 32'h0);
        chk("mis.flag",   {31'h0, misalign}, 32'h1);
        chk("mis.req",    {31'h0, dif.dmem_req}, 32'h0);
        chk("mis.rdata",  rdata_MEM, 32'h0);
        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        #1;
        chk("mis.clr", {31'h0, misalign}, 32'h0);
`else
        drive(1, 1, 0, 3'b010, 32'h0000_3001, 32'h0);
        access("mis", 0, 32'h0BAD_BEEF, 32'h0000_3000, 32'h0, 4'h0, 0,
               st);
        done_chk("mis", st, 2, 32'h0BAD_BEEF, 0);
`endif

        drive(0, 0, 0, 3'b000, 32'h0, 32'h0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
